// File: rtl/bht_predictor_pkg.sv
// Shared branch-predictor constants: 2-bit counter encodings, the default table
// size, and the helper that turns a counter state into a prediction.
package bht_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt2_e;

  localparam int DEFAULT_INDEX_BITS = 6;

  // The upper counter bit alone decides the direction (WT and ST predict taken).
  function automatic logic predicts_taken(input cnt2_e c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Fetch-side prediction port and EX-side resolved-branch update port of the BHT.
interface bht_predictor_if #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 16
);
  logic [WIDTH-1:0]    if_pc;
  logic                pred_taken;
  logic                upd_valid;
  logic [WIDTH-1:0]    upd_pc;
  logic                upd_taken;
  logic                upd_pred;
  logic                mispredict;
  logic [CNT_BITS-1:0] mispred_cnt;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_pred,
    input  pred_taken, mispredict, mispred_cnt
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_pred,
    output pred_taken, mispredict, mispred_cnt
  );
endinterface

// File: rtl/bht_predictor_sat_counter2.sv
// 2-bit saturating counter step: moves one state toward the resolved outcome
// and sticks at SNT/ST instead of wrapping.
module sat_counter2
  import bht_predictor_pkg::*;
(
  input  cnt2_e count,
  input  logic  taken,
  output cnt2_e next_count
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves next_count unassigned (no latch).
    next_count = count;
    case (count)
      SNT: next_count = taken ? WNT : SNT;
      WNT: next_count = taken ? WT  : SNT;
      WT:  next_count = taken ? ST  : WNT;
      ST:  next_count = taken ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped, untagged branch history table of 2-bit counters with a
// registered mispredict pulse and a saturating mispredict counter.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int CNT_BITS   = 16
) (
  input  logic            clk,
  input  logic            rst,
  bht_predictor_if.slave  bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [WIDTH-1:0]      rd_pc;
  logic [WIDTH-1:0]      wr_pc;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  cnt2_e                 bht_q [ENTRIES];
  cnt2_e                 next_cnt;
  logic                  is_mispred;
  logic                  mispredict_q;
  logic [CNT_BITS-1:0]   mispred_cnt_q;

  assign rd_pc  = bus.if_pc;
  assign wr_pc  = bus.upd_pc;
  // Word-aligned PCs: drop the byte offset, keep the low INDEX_BITS of the word address.
  assign rd_idx = INDEX_BITS'(rd_pc >> 2);
  assign wr_idx = INDEX_BITS'(wr_pc >> 2);

  sat_counter2 u_sat_counter2 (
    .count      (bht_q[wr_idx]),
    .taken      (bus.upd_taken),
    .next_count (next_cnt)
  );

  // NOTE: the table is a flop array so every entry can clear asynchronously; a RAM could not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= WNT;
    end else if (bus.upd_valid) begin
      bht_q[wr_idx] <= next_cnt;
    end
  end

  // Read of the pre-edge state; a same-cycle update is seen only from the next cycle.
  assign bus.pred_taken = predicts_taken(bht_q[rd_idx]);

  assign is_mispred = bus.upd_valid & (bus.upd_pred ^ bus.upd_taken);

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_q  <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q <= is_mispred;
      if (is_mispred && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_BITS'(1);
      end
    end
  end

  assign bus.mispredict  = mispredict_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed plus randomized bench for bht_predictor against an array-based
// reference model of the table and mispredict counter.
module tb_bht_predictor;

  localparam int WIDTH    = 32;
  localparam int IDX_BITS = 6;
  localparam int CNT_BITS = 4;
  localparam int N_ENT    = 64;
  localparam int CNT_MAX  = 15;

  logic clk = 1'b0;
  logic rst;

  bht_predictor_if #(.WIDTH(WIDTH), .CNT_BITS(CNT_BITS)) bus ();

  bht_predictor #(
    .WIDTH      (WIDTH),
    .INDEX_BITS (IDX_BITS),
    .CNT_BITS   (CNT_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: counter value 0..3 per entry, integer mispredict count.
  int m_tbl [N_ENT];
  int m_cnt;
  bit m_mp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % N_ENT);
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    return m_tbl[m_idx(pc)] >= 2;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_ENT; i++) m_tbl[i] = 1;
    m_cnt = 0;
    m_mp  = 0;
  endtask

  task automatic m_apply(input bit uv, input logic [31:0] upc, input bit ut, input bit up);
    int i;
    m_mp = uv && (up != ut);
    if (uv) begin
      i = m_idx(upc);
      if (ut) m_tbl[i] = (m_tbl[i] == 3) ? 3 : m_tbl[i] + 1;
      else    m_tbl[i] = (m_tbl[i] == 0) ? 0 : m_tbl[i] - 1;
    end
    if (m_mp && m_cnt < CNT_MAX) m_cnt++;
  endtask

  // Entered and left at posedge+1: checks the pre-edge prediction, clocks once,
  // then checks prediction and mispredict outputs against the model.
  task automatic do_cycle(input string tag, input logic [31:0] pc_if, input bit uv,
                          input logic [31:0] upc, input bit ut, input bit up);
    bus.if_pc     = pc_if;
    bus.upd_valid = uv;
    bus.upd_pc    = upc;
    bus.upd_taken = ut;
    bus.upd_pred  = up;
    #1;
    check({tag, "_pre_pred"}, 32'(bus.pred_taken), 32'(m_pred(pc_if)));
    @(posedge clk);
    if (!rst) m_apply(uv, upc, ut, up);
    #1;
    check({tag, "_post_pred"}, 32'(bus.pred_taken), 32'(m_pred(pc_if)));
    check({tag, "_mispredict"}, 32'(bus.mispredict), 32'(m_mp));
    check({tag, "_cnt"}, 32'(bus.mispred_cnt), 32'(m_cnt));
  endtask

  initial begin
    logic [31:0] upc;
    logic [31:0] ipc;
    rst           = 1'b1;
    bus.if_pc     = '0;
    bus.upd_valid = 1'b0;
    bus.upd_pc    = '0;
    bus.upd_taken = 1'b0;
    bus.upd_pred  = 1'b0;
    m_reset();
    #3;
    bus.if_pc = 32'h0040_0000; #1;
    check("rst_pred_a", 32'(bus.pred_taken), 32'd0);
    bus.if_pc = 32'h0040_00fc; #1;
    check("rst_pred_b", 32'(bus.pred_taken), 32'd0);
    check("rst_cnt", 32'(bus.mispred_cnt), 32'd0);
    check("rst_mispredict", 32'(bus.mispredict), 32'd0);

    // Update coincident with rst=1 is discarded.
    @(posedge clk); #1;
    do_cycle("upd_in_rst", 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1, 1'b0);
    check("upd_in_rst_const", 32'(bus.pred_taken), 32'd0);

    // Update presented as rst deasserts lands at the first edge with rst=0.
    rst = 1'b0;
    do_cycle("upd_at_release", 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1, 1'b1);
    check("upd_at_release_const", 32'(bus.pred_taken), 32'd1);

    do_cycle("idle_a", 32'h0040_0000, 1'b0, 32'h0, 1'b0, 1'b1);
    check("idle_pred_const", 32'(bus.pred_taken), 32'd0);
    check("idle_cnt_const", 32'(bus.mispred_cnt), 32'd0);

    // Saturate up to ST.
    do_cycle("tk1", 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 1'b1);
    check("tk1_const", 32'(bus.pred_taken), 32'd1);
    do_cycle("tk2", 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 1'b1);
    do_cycle("tk3", 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 1'b1);
    check("tk3_entry_st", 32'(m_tbl[m_idx(32'h0040_0010)]), 32'd3);

    // ST -> WT -> WNT.
    do_cycle("nt1", 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 1'b1);
    check("nt1_const", 32'(bus.pred_taken), 32'd1);
    do_cycle("nt2", 32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 1'b1);
    check("nt2_const", 32'(bus.pred_taken), 32'd0);

    // Same-cycle read and update to the same entry, no bypass.
    bus.if_pc = 32'h0040_0020; #1;
    check("bypass_pre_const", 32'(bus.pred_taken), 32'd0);
    do_cycle("bypass", 32'h0040_0020, 1'b1, 32'h0040_0020, 1'b1, 1'b0);
    check("bypass_post_const", 32'(bus.pred_taken), 32'd1);

    // Mispredict counter saturation.
    for (int k = 0; k < 20; k++) begin
      do_cycle("mp_run", 32'h0040_0030, 1'b1, 32'h0040_0030, 1'b0, 1'b1);
      check("mp_run_pulse", 32'(bus.mispredict), 32'd1);
    end
    check("mp_sat_const", 32'(bus.mispred_cnt), 32'd15);
    do_cycle("mp_ok", 32'h0040_0030, 1'b1, 32'h0040_0030, 1'b0, 1'b0);
    check("mp_ok_pulse", 32'(bus.mispredict), 32'd0);
    check("mp_ok_hold", 32'(bus.mispred_cnt), 32'd15);

    // Aliasing entries and asynchronous reset mid-cycle.
    do_cycle("alias", 32'h0040_0100, 1'b1, 32'h0040_0000, 1'b1, 1'b0);
    check("alias_b_const", 32'(bus.pred_taken), 32'd1);
    bus.upd_valid = 1'b0;
    bus.if_pc = 32'h0040_0000; #1;
    check("alias_a_const", 32'(bus.pred_taken), 32'd1);
    #1;
    rst = 1'b1;
    m_reset();
    #1;
    check("async_rst_a", 32'(bus.pred_taken), 32'd0);
    bus.if_pc = 32'h0040_0100; #1;
    check("async_rst_b", 32'(bus.pred_taken), 32'd0);
    check("async_rst_cnt", 32'(bus.mispred_cnt), 32'd0);
    check("async_rst_mispredict", 32'(bus.mispredict), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Random traffic over a small, partly aliasing PC set.
    for (int k = 0; k < 200; k++) begin
      upc = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 2)
          | (32'($urandom_range(0, 1)) << 8) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) ipc = upc;
      else ipc = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 2)
               | (32'($urandom_range(0, 1)) << 8) | 32'($urandom_range(0, 3));
      do_cycle("rand", ipc, $urandom_range(0, 3) != 0, upc,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 Parameter WIDTH, default 32: PC width in bits.
REQ-002 Parameter INDEX_BITS, default 6: table index width; the table holds 2^INDEX_BITS entries.
REQ-003 Parameter CNT_BITS, default 16: misprediction counter width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 if_pc  input  WIDTH  fetch-stage PC to predict.
REQ-007 pred_taken  output  1  prediction for if_pc; drives the next-PC 2:1 select (1 = branch target, 0 = PC+4).
REQ-008 upd_valid  input  1  resolved-branch update strobe from EX.
REQ-009 upd_pc  input  WIDTH  PC of the resolved branch.
REQ-010 upd_taken  input  1  actual branch outcome.
REQ-011 upd_pred  input  1  prediction originally issued for that branch.
REQ-012 mispredict  output  1  registered; high for one cycle after an update whose upd_pred != upd_taken.
REQ-013 mispred_cnt  output  CNT_BITS  registered count of mispredicted updates.

Function
REQ-014 Index = pc[INDEX_BITS+1:2] for both if_pc and upd_pc; pc[1:0] is ignored.
REQ-015 Each entry is a 2-bit saturating counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-016 pred_taken is combinational from the current table state: 1 iff entry[index(if_pc)] is WT or ST; zero-cycle latency.
REQ-017 On a clock edge with upd_valid=1, entry[index(upd_pc)] increments if upd_taken=1 and decrements if upd_taken=0.
REQ-018 Saturation: ST plus taken stays ST; SNT plus not-taken stays SNT; no wrap.
REQ-019 With upd_valid=0, no entry changes, mispredict goes to 0, and mispred_cnt holds.
REQ-020 Same-cycle read and update to the same index: pred_taken reflects the pre-update value; the new value is visible from the next cycle; no bypass.
REQ-021 Only one entry changes per cycle; aliasing PCs share an entry, with no tag check.
REQ-022 mispredict <= upd_valid & (upd_pred ^ upd_taken) every cycle.
REQ-023 mispred_cnt increments by 1 on each mispredicted update and saturates at all-ones; it does not wrap.
REQ-024 X or unknown inputs on if_pc when pred_taken is unused carry no requirement; upd_* are sampled only when upd_valid=1.

Reset
REQ-025 Asserting rst sets every entry to WNT (01), mispredict to 0 and mispred_cnt to 0 immediately, independent of clk.
REQ-026 While rst=1, pred_taken=0 for every if_pc.
REQ-027 An update presented in the cycle rst deasserts is applied at the first rising edge with rst=0; an update coincident with rst=1 is discarded.

Structure
REQ-028 Counter encodings SNT/WNT/WT/ST and the default INDEX_BITS go in the shared processor constants include file, not local literals.
REQ-029 The per-entry update rule is one sub-module, sat_counter2 (in: count, taken; out: next count), instantiated once on the update path.
REQ-030 The table is a flop array with asynchronous reset, not an inferred RAM, so that REQ-025 holds.

Verification
REQ-031 Reset, then if_pc=0x00400000 -> pred_taken=0; mispred_cnt=0.
REQ-032 Three updates, upd_pc=0x00400010 taken -> entry goes WNT->WT->ST->ST; pred_taken for if_pc=0x00400010 is 1 from the cycle after the first update.
REQ-033 From ST, two not-taken updates at the same PC -> WT then WNT; pred_taken=0 after the second update.
REQ-034 if_pc=upd_pc=0x00400020 (WNT) with a taken update in the same cycle -> pred_taken=0 that cycle and 1 the next cycle.
REQ-035 Mispredicted updates (upd_pred=1, upd_taken=0) with CNT_BITS=4: after 20 such updates mispred_cnt=15; mispredict pulses 1 each cycle; a correct update -> mispredict=0 and the count holds.
REQ-036 PCs 0x00400000 and 0x00400100 (alias when INDEX_BITS=6): a taken update to one -> both predict the same; rst mid-sequence -> both return to WNT asynchronously.
